// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_t   : operand source select for the Execute-stage ALU inputs
//   mem_state_t : data-memory wait FSM states
//   WAITCNT_W   : width of the wait-cycle counter used for the timeout
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam int unsigned WAITCNT_W = 16;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding compare for a single Execute-stage source operand.
// Ports:
//   RsE                 : source register of the operand in Execute
//   RdM, RegWriteM      : destination / write enable in Memory
//   RdW, RegWriteW      : destination / write enable in Writeback
//   Forward             : FWD_M, FWD_W or FWD_RF (Memory wins over Writeback)
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] RsE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  output fwd_sel_t      Forward
);

  always_comb begin
    Forward = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == RsE)) begin
      Forward = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == RsE)) begin
      Forward = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core.
// Ports:
//   clk, reset (async, active-low)
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, LoadE, PCSrcE, RdM/RdW, RegWriteM/RegWriteW
//   MemReqM/MemReadyM : data-memory request / completion handshake
//   CntClr            : synchronous clear of both event counters
//   ForwardAE/BE      : ALU operand selects
//   StallF/D/E/M, FlushD/E/W : pipeline register controls
//   MemBusy, MemErr   : wait FSM in WAIT / sticky timeout flag
//   StallCount, FlushCount   : saturating event counters
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned AW          = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    Rs1D,
  input  logic [AW-1:0]    Rs2D,
  input  logic [AW-1:0]    Rs1E,
  input  logic [AW-1:0]    Rs2E,
  input  logic [AW-1:0]    RdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic [AW-1:0]    RdM,
  input  logic [AW-1:0]    RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             CntClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemBusy,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [WAITCNT_W-1:0] ERR_AT = WAITCNT_W'(MEM_TIMEOUT - 1);

  fwd_sel_t fwd_a, fwd_b;

  hazard_fwd_sel #(.AW(AW)) u_fwd_a (
    .RsE(Rs1E), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Forward(fwd_a)
  );

  hazard_fwd_sel #(.AW(AW)) u_fwd_b (
    .RsE(Rs2E), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Forward(fwd_b)
  );

  assign ForwardAE = reset ? fwd_a : FWD_RF;
  assign ForwardBE = reset ? fwd_b : FWD_RF;

  logic mem_stall, lw_stall, br_flush;

  // mem_stall acts in the first wait cycle, before the FSM has left IDLE.
  assign mem_stall = MemReqM & ~MemReadyM;
  assign lw_stall  = LoadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign br_flush  = reset & ~mem_stall & PCSrcE;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      // Freeze F..M; a pending branch or load-use is re-evaluated on release.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  mem_state_t           state_q, state_d;
  logic [WAITCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (mem_stall) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (MemReadyM || !MemReqM) begin
          state_d = IDLE;
        end else begin
          if (wait_cnt_q == ERR_AT) begin
            err_d = 1'b1;
          end
          wait_cnt_d = wait_cnt_q + WAITCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign MemBusy = (state_q == WAIT);
  assign MemErr  = err_q;

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (CntClr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (br_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (CNT_W=4, MEM_TIMEOUT=4). Expected outputs
// are queued when a step is driven and popped when the outputs are sampled.
module tb_hazard_unit;

  logic       clk, reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       LoadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM, CntClr;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       MemBusy, MemErr;
  logic [3:0] StallCount, FlushCount;

  hazard_unit #(.AW(5), .CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClr(CntClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemBusy(MemBusy), .MemErr(MemErr),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] st;   // {StallF, StallD, StallE, StallM}
    logic [2:0] fl;   // {FlushD, FlushE, FlushW}
    logic       busy;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  function automatic exp_t E(logic [1:0] fa, logic [1:0] fb, logic [3:0] st,
                             logic [2:0] fl, logic busy, logic err,
                             logic [3:0] sc, logic [3:0] fc);
    exp_t e;
    e.fa = fa; e.fb = fb; e.st = st; e.fl = fl;
    e.busy = busy; e.err = err; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  function automatic logic [3:0] sat(int i);
    return (i > 15) ? 4'd15 : 4'(i);
  endfunction

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL step %0d %s: observed %0h expected %0h", n_step, tag, obs, expv);
    end
  endtask

  task automatic clr();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    LoadE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0; CntClr = 1'b0;
  endtask

  // Inputs are driven just after a falling edge; outputs are sampled 1 time
  // unit later, well clear of the next rising edge.
  task automatic step(exp_t e);
    exp_t x;
    exp_q.push_back(e);
    #1;
    x = exp_q.pop_front();
    cmp("ForwardAE", 32'(ForwardAE), 32'(x.fa));
    cmp("ForwardBE", 32'(ForwardBE), 32'(x.fb));
    cmp("Stall",     32'({StallF, StallD, StallE, StallM}), 32'(x.st));
    cmp("Flush",     32'({FlushD, FlushE, FlushW}), 32'(x.fl));
    cmp("MemBusy",   32'(MemBusy), 32'(x.busy));
    cmp("MemErr",    32'(MemErr), 32'(x.err));
    cmp("StallCount", 32'(StallCount), 32'(x.sc));
    cmp("FlushCount", 32'(FlushCount), 32'(x.fc));
    n_step++;
    @(negedge clk);
  endtask

  initial begin
    // Reset low: outputs forced regardless of inputs.
    reset = 1'b0; clr();
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; MemReqM = 1'b1; PCSrcE = 1'b1;
    step(E(0, 0, 4'h0, 3'b111, 0, 0, 0, 0));
    reset = 1'b1; clr();
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 0, 0));

    // Forwarding.
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd6;
    step(E(2, 0, 4'h0, 3'b000, 0, 0, 0, 0));
    RegWriteM = 1'b0;
    step(E(1, 0, 4'h0, 3'b000, 0, 0, 0, 0));
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0;
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 0, 0));
    Rs1E = 5'd0; Rs2E = 5'd0;
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 0, 0));
    RdM = 5'd9; RdW = 5'd6; Rs1E = 5'd6; Rs2E = 5'd9;
    step(E(1, 2, 4'h0, 3'b000, 0, 0, 0, 0));
    RdM = 5'd6; Rs2E = 5'd6;
    step(E(2, 2, 4'h0, 3'b000, 0, 0, 0, 0));
    clr();

    // Load-use.
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    step(E(0, 0, 4'b1100, 3'b010, 0, 0, 0, 0));
    LoadE = 1'b0; RdE = 5'd0; Rs2D = 5'd0;
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 1, 0));
    LoadE = 1'b1;
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 1, 0));
    RdE = 5'd7; Rs1D = 5'd7; Rs2D = 5'd3;
    step(E(0, 0, 4'b1100, 3'b010, 0, 0, 1, 0));

    // Branch beats load-use.
    clr(); LoadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
    step(E(0, 0, 4'h0, 3'b110, 0, 0, 2, 0));
    clr();
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 2, 1));

    // Three wait cycles with a concurrent branch, then ready.
    MemReqM = 1'b1; PCSrcE = 1'b1;
    step(E(0, 0, 4'hF, 3'b001, 0, 0, 2, 1));
    step(E(0, 0, 4'hF, 3'b001, 1, 0, 3, 1));
    step(E(0, 0, 4'hF, 3'b001, 1, 0, 4, 1));
    MemReadyM = 1'b1;
    step(E(0, 0, 4'h0, 3'b110, 1, 0, 5, 1));
    clr();
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 5, 2));

    // Timeout: MemErr appears after the 4th WAIT cycle and is sticky.
    MemReqM = 1'b1;
    step(E(0, 0, 4'hF, 3'b001, 0, 0, 5, 2));
    step(E(0, 0, 4'hF, 3'b001, 1, 0, 6, 2));
    step(E(0, 0, 4'hF, 3'b001, 1, 0, 7, 2));
    step(E(0, 0, 4'hF, 3'b001, 1, 0, 8, 2));
    step(E(0, 0, 4'hF, 3'b001, 1, 0, 9, 2));
    step(E(0, 0, 4'hF, 3'b001, 1, 1, 10, 2));
    MemReadyM = 1'b1;
    step(E(0, 0, 4'h0, 3'b000, 1, 1, 11, 2));
    clr();
    step(E(0, 0, 4'h0, 3'b000, 0, 1, 11, 2));

    // Abandoned access leaves WAIT.
    MemReqM = 1'b1;
    step(E(0, 0, 4'hF, 3'b001, 0, 1, 11, 2));
    step(E(0, 0, 4'hF, 3'b001, 1, 1, 12, 2));
    MemReqM = 1'b0;
    step(E(0, 0, 4'h0, 3'b000, 1, 1, 13, 2));
    step(E(0, 0, 4'h0, 3'b000, 0, 1, 13, 2));

    // Reset asserted mid-WAIT.
    MemReqM = 1'b1;
    step(E(0, 0, 4'hF, 3'b001, 0, 1, 13, 2));
    step(E(0, 0, 4'hF, 3'b001, 1, 1, 14, 2));
    reset = 1'b0;
    step(E(0, 0, 4'h0, 3'b111, 0, 0, 0, 0));
    reset = 1'b1;
    step(E(0, 0, 4'hF, 3'b001, 0, 0, 0, 0));
    MemReqM = 1'b0;
    step(E(0, 0, 4'h0, 3'b000, 1, 0, 1, 0));
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 1, 0));

    // StallCount saturation and clear priority.
    CntClr = 1'b1;
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 1, 0));
    CntClr = 1'b0; LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    for (int i = 0; i < 20; i++) begin
      step(E(0, 0, 4'b1100, 3'b010, 0, 0, sat(i), 0));
    end
    clr();
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 15, 0));
    CntClr = 1'b1; LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    step(E(0, 0, 4'b1100, 3'b010, 0, 0, 15, 0));
    clr();
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 0, 0));

    // FlushCount saturation and clear.
    PCSrcE = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step(E(0, 0, 4'h0, 3'b110, 0, 0, 0, sat(i)));
    end
    clr();
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 0, 15));
    CntClr = 1'b1;
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 0, 15));
    clr();
    step(E(0, 0, 4'h0, 3'b000, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W).
- Replaces the hardwired stall/flush constants and the standalone forwarding unit.
- Generates forwarding selects, load-use stalls and branch/jump flushes.
- Adds a data-memory wait FSM, driven by a ready handshake, with a timeout error flag.
- Keeps saturating stall/flush event counters for performance monitoring.

Parameters:
- AW, 5: register-address width (5 for RV32I, 4 for RV32E).
- CNT_W, 32: width of StallCount and FlushCount.
- MEM_TIMEOUT, 16: number of consecutive wait cycles before MemErr sets. Legal range 1..2^16-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  AW  source registers of the instruction in Decode.
- Rs1E, Rs2E, RdE  in  AW  source and destination registers of the instruction in Execute.
- LoadE  in  1  the instruction in Execute is a load (ResultSrcE==2'b01).
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- RdM, RdW  in  AW  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
- MemReqM  in  1  a load or store occupies Memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- CntClr  in  1  synchronous clear of both counters.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALUResultM.
- StallF, StallD, StallE, StallM  out  1  hold the PC register and the F/D, D/E and E/M registers.
- FlushD, FlushE, FlushW  out  1  insert a bubble into the F/D, D/E and M/W registers.
- MemBusy  out  1  the FSM is in WAIT.
- MemErr  out  1  sticky timeout flag.
- StallCount, FlushCount  out  CNT_W  event counters.

Behaviour:
- Forwarding is combinational and evaluated per operand X in {1,2}:
  - 10 if RegWriteM & RdM!=0 & RdM==RsXE;
  - else 01 if RegWriteW & RdW!=0 & RdW==RsXE;
  - else 00.
  - Memory has priority over Writeback.
- lwStall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall = MemReqM & ~MemReadyM. It takes effect combinationally in the first wait cycle, independent of the FSM state.
- Priority order, highest first:
  1. memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Any pending branch or load-use stays frozen in E and is re-evaluated on the release cycle.
  2. PCSrcE: FlushD=FlushE=1, with StallF=StallD=0 even if lwStall is also true.
  3. lwStall: StallF=StallD=1, FlushE=1.
  4. Otherwise all stall and flush outputs are 0.
- FSM states: IDLE, WAIT.
  - IDLE -> WAIT when memStall.
  - WAIT -> IDLE when MemReadyM, or when MemReqM drops (access abandoned).
  - WaitCnt (16 bits) clears on entry to WAIT and increments every WAIT cycle.
  - When WaitCnt reaches MEM_TIMEOUT-1 while still waiting, MemErr sets and stays set until reset. The stall continues; it is not broken.
  - MemBusy = (state==WAIT).
- Counters:
  - StallCount increments on every cycle with StallF=1.
  - FlushCount increments on every cycle with PCSrcE-driven FlushD=1.
  - Both saturate at 2^CNT_W-1; they do not wrap.
  - CntClr has priority over increment in the same cycle.
- Reset (reset==0), asynchronous:
  - State values: FSM=IDLE, WaitCnt=0, MemErr=0, counters=0.
  - Output values while reset is low: ForwardAE/BE=00, all stalls 0, FlushD=FlushE=FlushW=1.
  - Reset asserted mid-WAIT aborts the wait immediately.
  - On release, outputs follow the rules above from the first clock.
- All stall and flush outputs are combinational from the inputs plus state. No added latency.

Decomposition:
- hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
  - mem_state_t enum (IDLE, WAIT);
  - localparam WAITCNT_W=16.
- Sub-module hazard_fwd_sel(AW): one operand's forwarding compare, instantiated twice (A and B).
- The FSM and counters stay in hazard_unit.

Test Plan:
1. add x5 in M (RegWriteM=1, RdM=5) and in W (RdW=5); Rs1E=5 -> ForwardAE=10. With RegWriteM=0 -> 01. With RdM=RdW=0 -> 00.
2. LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle, StallCount+1. Same with RdE=0 -> no stall.
3. PCSrcE=1 together with LoadE=1, RdE=Rs1D=3 -> FlushD=FlushE=1, StallF=0, FlushCount+1.
4. MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> stalls high and FlushW=1 for 3 cycles, MemBusy high from cycle 2 to cycle 4 (the release cycle), then IDLE. A concurrent PCSrcE is flushed only on the release cycle.
5. MEM_TIMEOUT=4, MemReadyM held 0 -> MemErr sets after the 4th wait cycle and stays 1 after ready. reset low mid-WAIT -> IDLE, MemErr=0, FlushD/E/W=1.
6. CNT_W=4: 20 stall cycles -> StallCount=15 (saturated). CntClr together with a stall -> StallCount=0.
